// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, fetch constants and an
// alignment helper. Imported by the fetch unit, decode and the bench.
package fetch_pkg;

  // Instruction word width (fixed at 32 regardless of XLEN)
  localparam int unsigned ILEN = 32;

  // Sequential PC increment in bytes
  localparam int unsigned PC_STEP = 4;

  // addi x0,x0,0 -- presented after reset and on a misaligned fetch
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

  // A fetch address is usable only on a 4-byte boundary
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage : fetch_pkg

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage sitting between the program counter and decode.
// Reads the current PC, fetches the word over a req/ack memory handshake and
// offers it to decode over valid/ready. Drives the PC write port for the
// reset vector, sequential advance and branch/jump redirects.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   pc_in                            current PC value
//   pc_wr, pc_next                   PC write enable / value (combinational)
//   redirect_valid, redirect_pc      taken branch/jump pulse and target
//   imem_req, imem_addr              memory request, address held while req=1
//   imem_ack, imem_rdata             memory response, data valid with ack only
//   instr_valid, instr_ready         handshake towards decode
//   instr, instr_pc, instr_fault     fetched word, its address, misalign flag
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_wr,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            drop_q, drop_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_fault_q, instr_fault_d;

  logic [XLEN-1:0] addr_inc;
  logic            addr_ok;

  // Sequential successor, modulo 2^XLEN
  assign addr_inc = addr_q + XLEN'(PC_STEP);
  assign addr_ok  = is_aligned(addr_q[1:0]);

  // Next-state, PC write and handshake outputs
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    drop_d        = drop_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_fault_d = instr_fault_q;
    pc_wr         = 1'b0;
    pc_next       = addr_q;
    imem_req      = 1'b0;
    imem_addr     = addr_q;
    instr_valid   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Redirects are ignored here; the reset vector always goes first
        pc_wr   = 1'b1;
        pc_next = RESET_VECTOR;
        addr_d  = RESET_VECTOR;
        drop_d  = 1'b0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (!addr_ok) begin
          // Misaligned target: never touch memory, hand decode a faulting NOP
          if (redirect_valid) begin
            pc_wr   = 1'b1;
            pc_next = redirect_pc;
            addr_d  = redirect_pc;
          end else begin
            instr_d       = NOP_INSTR;
            instr_pc_d    = addr_q;
            instr_fault_d = 1'b1;
            state_d       = S_VALID;
          end
        end else begin
          imem_req = 1'b1;
          if (redirect_valid) begin
            pc_wr   = 1'b1;
            pc_next = redirect_pc;
            if (imem_ack) begin
              // Response lands with the redirect: discard and refetch now
              addr_d = redirect_pc;
              drop_d = 1'b0;
            end else begin
              // Request in flight keeps its address; throw its data away later
              drop_d = 1'b1;
            end
          end else if (imem_ack) begin
            if (drop_q) begin
              // Stale response; pc_in holds the most recent redirect target
              drop_d = 1'b0;
              addr_d = pc_in;
            end else begin
              instr_d       = imem_rdata;
              instr_pc_d    = addr_q;
              instr_fault_d = 1'b0;
              state_d       = S_VALID;
            end
          end
        end
      end

      S_VALID: begin
        instr_valid = 1'b1;
        if (redirect_valid) begin
          pc_wr   = 1'b1;
          pc_next = redirect_pc;
          addr_d  = redirect_pc;
          state_d = S_WAIT;
        end else if (instr_ready) begin
          pc_wr   = 1'b1;
          pc_next = addr_inc;
          addr_d  = addr_inc;
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Nothing leaves the block while reset is held
    if (rst) begin
      pc_wr       = 1'b0;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
    end
  end

  // State, fetch address, drop flag and instruction holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= RESET_VECTOR;
      drop_q        <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      instr_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      drop_q        <= drop_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_fault_q <= instr_fault_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_fault = instr_fault_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a program counter register, a memory model with
// programmable ack delay, directed scenarios and a randomized run checked
// against an architectural next-PC model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic            pc_wr;
  logic [XLEN-1:0] pc_next;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_fault;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_delay = 0;
  int mem_cnt;

  instr_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .pc_wr         (pc_wr),
    .pc_next       (pc_next),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_fault   (instr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct content per address so stale data is recognisable
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Program counter
  always_ff @(posedge clk) begin
    if (rst) pc_in <= '0;
    else if (pc_wr) pc_in <= pc_next;
  end

  // Memory: ack after mem_delay waiting cycles of a continuous request
  always_ff @(posedge clk) begin
    if (rst || !imem_req || imem_ack) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end
  assign imem_ack   = imem_req && (mem_cnt >= mem_delay);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        return;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; instr_ready = 1'b1;
    next_cycle();
    next_cycle();
    n_checks++;
    if ({pc_wr, imem_req, instr_valid} !== 3'b000)
      $display("FAIL reset_ctrl got pc_wr/req/valid=%b exp 000", {pc_wr, imem_req, instr_valid});
    else n_pass++;
    n_checks++;
    if (instr !== NOP_INSTR) $display("FAIL reset_instr got %h exp %h", instr, NOP_INSTR);
    else n_pass++;
    n_checks++;
    if ({instr_pc, instr_fault} !== {32'h0, 1'b0})
      $display("FAIL reset_pc_fault got %h/%b exp 0/0", instr_pc, instr_fault);
    else n_pass++;
    redirect_valid = 1'b0;
  endtask

  task automatic test_sequential();
    bit ok;
    mem_delay = 0; instr_ready = 1'b1;
    do_reset();
    n_checks++;
    if (!(pc_wr === 1'b1 && pc_next === 32'h0 && imem_req === 1'b0))
      $display("FAIL seq_reset_vector got pc_wr=%b pc_next=%h exp 1/00000000", pc_wr, pc_next);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      wait_valid(10, ok);
      n_checks++;
      if (!ok) $display("FAIL seq_timeout got no valid exp valid k=%0d", k);
      else n_pass++;
      n_checks++;
      if (instr_pc !== 32'(4 * k) || instr !== mem_word(32'(4 * k)) || instr_fault !== 1'b0)
        $display("FAIL seq_instr got pc=%h instr=%h exp pc=%h instr=%h", instr_pc, instr,
                 32'(4 * k), mem_word(32'(4 * k)));
      else n_pass++;
      n_checks++;
      if (pc_wr !== 1'b1 || pc_next !== 32'(4 * k + 4))
        $display("FAIL seq_advance got pc_wr=%b pc_next=%h exp 1/%h", pc_wr, pc_next, 32'(4 * k + 4));
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_mem_latency();
    mem_delay = 3; instr_ready = 1'b1;
    do_reset();
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_wr !== 1'b0 || instr_valid !== 1'b0)
        $display("FAIL lat_wait got req=%b addr=%h pc_wr=%b valid=%b exp 1/0/0/0 i=%0d",
                 imem_req, imem_addr, pc_wr, instr_valid, i);
      else n_pass++;
      n_checks++;
      if (imem_ack !== (i == 3)) $display("FAIL lat_ack got %b exp %b i=%0d", imem_ack, (i == 3), i);
      else n_pass++;
      next_cycle();
    end
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0))
      $display("FAIL lat_deliver got valid=%b pc=%h instr=%h exp 1/0/%h", instr_valid, instr_pc,
               instr, mem_word(32'h0));
    else n_pass++;
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    mem_delay = 0; instr_ready = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      next_cycle();
      if (instr_valid && instr_pc == 32'h10) begin
        instr_ready = 1'b0;
        #1;
        found = 1'b1;
      end
    end
    n_checks++;
    if (!found) $display("FAIL stall_reach got no instr at 10 exp instr at 10");
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== mem_word(32'h10) ||
          pc_wr !== 1'b0 || pc_in !== 32'h10)
        $display("FAIL stall_hold got valid=%b pc=%h instr=%h pc_wr=%b pc_in=%h exp 1/10/%h/0/10",
                 instr_valid, instr_pc, instr, pc_wr, pc_in, mem_word(32'h10));
      else n_pass++;
      next_cycle();
    end
    mem_delay = 3; instr_ready = 1'b1;
    #1;
    n_checks++;
    if (pc_wr !== 1'b1 || pc_next !== 32'h14)
      $display("FAIL stall_release got pc_wr=%b pc_next=%h exp 1/14", pc_wr, pc_next);
    else n_pass++;
    next_cycle();
    n_checks++;
    if (pc_in !== 32'h14) $display("FAIL stall_pc got %h exp 14", pc_in);
    else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    bit got = 1'b0;
    bit seen_new = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_ack !== 1'b0 || pc_wr !== 1'b1 || pc_next !== 32'h200)
      $display("FAIL redir_pulse got req=%b ack=%b pc_wr=%b pc_next=%h exp 1/0/1/200",
               imem_req, imem_ack, pc_wr, pc_next);
    else n_pass++;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (pc_in !== 32'h200 || imem_req !== 1'b1 || imem_addr !== 32'h14)
      $display("FAIL redir_old_addr got pc=%h req=%b addr=%h exp 200/1/14", pc_in, imem_req, imem_addr);
    else n_pass++;
    for (int i = 0; i < 20 && !got; i++) begin
      if (instr_valid) got = 1'b1;
      else begin
        if (imem_req && imem_addr == 32'h200) seen_new = 1'b1;
        n_checks++;
        if (pc_wr !== 1'b0) $display("FAIL redir_no_write got pc_wr=%b exp 0", pc_wr);
        else n_pass++;
        next_cycle();
      end
    end
    n_checks++;
    if (!got || !seen_new) $display("FAIL redir_refetch got valid=%b req200=%b exp 1/1", got, seen_new);
    else n_pass++;
    n_checks++;
    if (instr_pc !== 32'h200 || instr !== mem_word(32'h200) || instr_fault !== 1'b0)
      $display("FAIL redir_instr got pc=%h instr=%h exp 200/%h", instr_pc, instr, mem_word(32'h200));
    else n_pass++;
  endtask

  task automatic test_misaligned();
    bit ok;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    #1;
    n_checks++;
    if (pc_wr !== 1'b1 || pc_next !== 32'h102)
      $display("FAIL mis_redir got pc_wr=%b pc_next=%h exp 1/102", pc_wr, pc_next);
    else n_pass++;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL mis_no_req got req=%b valid=%b exp 0/0", imem_req, instr_valid);
    else n_pass++;
    next_cycle();
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== NOP_INSTR || instr_pc !== 32'h102 || instr_fault !== 1'b1)
      $display("FAIL mis_fault got valid=%b instr=%h pc=%h fault=%b exp 1/00000013/102/1",
               instr_valid, instr, instr_pc, instr_fault);
    else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    n_checks++;
    if (pc_wr !== 1'b1 || pc_next !== 32'h100)
      $display("FAIL mis_recover_redir got pc_wr=%b pc_next=%h exp 1/100", pc_wr, pc_next);
    else n_pass++;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    wait_valid(20, ok);
    n_checks++;
    if (!ok || instr_pc !== 32'h100 || instr !== mem_word(32'h100) || instr_fault !== 1'b0)
      $display("FAIL mis_recover got ok=%b pc=%h instr=%h fault=%b exp 1/100/%h/0",
               ok, instr_pc, instr, instr_fault, mem_word(32'h100));
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    mem_delay = 0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    #1;
    wait_valid(10, ok);
    n_checks++;
    if (!ok || instr_pc !== 32'hFFFF_FFFC || instr !== mem_word(32'hFFFF_FFFC))
      $display("FAIL wrap_instr got ok=%b pc=%h instr=%h exp 1/fffffffc/%h", ok, instr_pc, instr,
               mem_word(32'hFFFF_FFFC));
    else n_pass++;
    n_checks++;
    if (pc_wr !== 1'b1 || pc_next !== 32'h0)
      $display("FAIL wrap_next got pc_wr=%b pc_next=%h exp 1/00000000", pc_wr, pc_next);
    else n_pass++;
    mem_delay = 3;
    next_cycle();
    n_checks++;
    if (pc_in !== 32'h0 || imem_req !== 1'b1 || imem_ack !== 1'b0)
      $display("FAIL wrap_pc got pc=%h req=%b ack=%b exp 0/1/0", pc_in, imem_req, imem_ack);
    else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    next_cycle();
    redirect_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++;
    if ({pc_wr, imem_req, instr_valid} !== 3'b000)
      $display("FAIL midrst_quiet got pc_wr/req/valid=%b exp 000", {pc_wr, imem_req, instr_valid});
    else n_pass++;
    next_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if (pc_wr !== 1'b1 || pc_next !== 32'h0)
      $display("FAIL midrst_vector got pc_wr=%b pc_next=%h exp 1/00000000", pc_wr, pc_next);
    else n_pass++;
    next_cycle();
    wait_valid(20, ok);
    n_checks++;
    if (!ok || instr_pc !== 32'h0 || instr !== mem_word(32'h0))
      $display("FAIL midrst_fetch got ok=%b pc=%h instr=%h exp 1/0/%h", ok, instr_pc, instr,
               mem_word(32'h0));
    else n_pass++;
  endtask

  // Architectural model: the next instruction decode must see is exp_pc,
  // replaced by each redirect and stepped by 4 on each acceptance.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_word;
    logic        exp_fault;
    do_reset();
    n_checks++;
    if (pc_wr !== 1'b1 || pc_next !== 32'h0)
      $display("FAIL rnd_start got pc_wr=%b pc_next=%h exp 1/0", pc_wr, pc_next);
    else n_pass++;
    exp_pc = 32'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      next_cycle();
      mem_delay   = int'($urandom_range(0, 3));
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF8;
      #1;
      exp_fault = (exp_pc[1:0] != 2'b00);
      exp_word  = exp_fault ? NOP_INSTR : mem_word(exp_pc);
      n_checks++;
      if (pc_in !== exp_pc) $display("FAIL rnd_pc got %h exp %h cyc=%0d", pc_in, exp_pc, cyc);
      else n_pass++;
      if (instr_valid) begin
        n_checks++;
        if (instr_pc !== exp_pc || instr !== exp_word || instr_fault !== exp_fault)
          $display("FAIL rnd_instr got pc=%h instr=%h fault=%b exp %h/%h/%b cyc=%0d",
                   instr_pc, instr, instr_fault, exp_pc, exp_word, exp_fault, cyc);
        else n_pass++;
      end
      n_checks++;
      if (redirect_valid) begin
        if (pc_wr !== 1'b1 || pc_next !== redirect_pc)
          $display("FAIL rnd_redirect got pc_wr=%b pc_next=%h exp 1/%h", pc_wr, pc_next, redirect_pc);
        else n_pass++;
        exp_pc = redirect_pc;
      end else if (instr_valid && instr_ready) begin
        if (pc_wr !== 1'b1 || pc_next !== exp_pc + 32'd4)
          $display("FAIL rnd_advance got pc_wr=%b pc_next=%h exp 1/%h", pc_wr, pc_next, exp_pc + 32'd4);
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
      end else begin
        if (pc_wr !== 1'b0) $display("FAIL rnd_idle_write got pc_wr=%b exp 0 cyc=%0d", pc_wr, cyc);
        else n_pass++;
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    test_reset();
    test_sequential();
    test_mem_latency();
    test_stall();
    test_redirect_inflight();
    test_misaligned();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch_unit
